// File: rtl/pipe_skid_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_layer_pkg
// Brief    : Shared state encoding and stall-counter constants for the skid layer.
// Revision : 1.0
// ============================================================================
package pipe_skid_layer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_layer_reg_en.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_en
// Brief    : WIDTH-bit data register with load enable and async active-low clear.
// Revision : 1.0
// ============================================================================
module pipe_reg_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_layer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_layer
// Brief    : Elastic valid/ready pipeline stage (main + one-entry skid register).
//            Optional back-pressure counter enabled by SKID_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
module pipe_skid_layer
    import pipe_skid_layer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_BUSY  = BUSY;
    localparam logic [1:0] ST_FULL  = FULL;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_load;
    logic             w_skid_load;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_next           = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_load = 1'b1;
                    w_next      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_load = 1'b1;
                    w_next      = ST_FULL;
                end else if (w_out_fire) begin
                    w_next      = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so upstream is ignored entirely
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_next           = ST_BUSY;
                end
            end
            default: begin
                w_next = ST_EMPTY;
            end
        endcase
    end

    // Handshake flags are registered from the next state, keeping both
    // ready and valid free of combinational paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next != ST_EMPTY);
            r_in_ready  <= (w_next != ST_FULL);
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    pipe_reg_en #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_main_load),
        .d     (w_main_d),
        .q     (w_main_q)
    );

    pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_skid_load),
        .d     (in_data),
        .q     (w_skid_q)
    );

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_data  = w_main_q;

`ifdef SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
